// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
//   Bundles the pc_sequencer control, LUT-programming and status signals.
//
//   Parameters
//     PW : program counter width (instruction memory depth 2^PW)
//     LW : branch-target LUT index width (2^LW entries)
//
//   Signals (direction given from the sequencer's side, i.e. the slave modport)
//     start        in   pulse, begin execution at address 0
//     halt_instr   in   current instruction is a halt
//     branch_en    in   current instruction is a conditional branch
//     branch_cond  in   branch condition (1 = taken)
//     target_idx   in   LUT index holding the branch target
//     lut_we       in   LUT write enable
//     lut_addr     in   LUT write index
//     lut_data     in   LUT write data (absolute target address)
//     pc           out  current instruction address
//     fetch_valid  out  pc holds a live instruction
//     done         out  program halted
//     wrap_flag    out  sticky, pc wrapped from 2^PW-1 to 0 while running
//     cycle_cnt    out  16-bit run-cycle counter (only with PC_SEQ_CYCLE_COUNT_EN)
//
//   Modports
//     master : the decoder / top level that drives the sequencer
//     slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int PW = 10,
    parameter int LW = 4
);
    logic          start;
    logic          halt_instr;
    logic          branch_en;
    logic          branch_cond;
    logic [LW-1:0] target_idx;
    logic          lut_we;
    logic [LW-1:0] lut_addr;
    logic [PW-1:0] lut_data;
    logic [PW-1:0] pc;
    logic          fetch_valid;
    logic          done;
    logic          wrap_flag;
`ifdef PC_SEQ_CYCLE_COUNT_EN
    logic [15:0]   cycle_cnt;

    modport master (
        output start, halt_instr, branch_en, branch_cond, target_idx,
               lut_we, lut_addr, lut_data,
        input  pc, fetch_valid, done, wrap_flag, cycle_cnt
    );

    modport slave (
        input  start, halt_instr, branch_en, branch_cond, target_idx,
               lut_we, lut_addr, lut_data,
        output pc, fetch_valid, done, wrap_flag, cycle_cnt
    );
`else
    modport master (
        output start, halt_instr, branch_en, branch_cond, target_idx,
               lut_we, lut_addr, lut_data,
        input  pc, fetch_valid, done, wrap_flag
    );

    modport slave (
        input  start, halt_instr, branch_en, branch_cond, target_idx,
               lut_we, lut_addr, lut_data,
        output pc, fetch_valid, done, wrap_flag
    );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter and fetch sequencer for the 8-bit datapath. Each cycle it
//   presents the instruction-memory address, resolves taken branches through a
//   small programmable branch-target LUT, and reports start/halt/done status.
//
//   Ports
//     clk    in   system clock, all state updates on the rising edge
//     reset  in   synchronous, active-high; clears FSM, outputs and the LUT
//     bus    slave modport of pc_sequencer_if (control in, status out)
//
//   Optional feature
//     PC_SEQ_CYCLE_COUNT_EN : when defined, adds bus.cycle_cnt, a saturating
//     16-bit count of clock edges spent in RUN (cleared by reset and by start).
//
//   Timing
//     All outputs are registered. A decision taken on inputs sampled at edge N
//     is visible on pc at edge N; there are no delay slots.
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int PW = 10,
    parameter int LW = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    localparam int            LUT_N  = 2 ** LW;
    localparam logic [PW-1:0] PC_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] pc_q;
    logic          fetch_valid_q;
    logic          done_q;
    logic          wrap_q;
    logic [PW-1:0] lut [LUT_N];

    logic          branch_taken;

    // Branch decision; only acted on in RUN and only if no halt is pending.
    assign branch_taken = bus.branch_en & bus.branch_cond;

    // Single FSM block. The LUT lives here too so reset clears it in the same
    // edge as the state; the LUT read in RUN uses the pre-edge contents, so a
    // same-cycle write to the branch's own index is not seen until next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pc_q          <= '0;
            fetch_valid_q <= 1'b0;
            done_q        <= 1'b0;
            wrap_q        <= 1'b0;
            for (int i = 0; i < LUT_N; i++) begin
                lut[i] <= '0;
            end
        end else begin
            if (bus.lut_we) begin
                lut[bus.lut_addr] <= bus.lut_data;
            end

            case (state)
                S_IDLE: begin
                    pc_q          <= '0;
                    fetch_valid_q <= 1'b0;
                    done_q        <= 1'b0;
                    if (bus.start) begin
                        state         <= S_RUN;
                        fetch_valid_q <= 1'b1;
                        wrap_q        <= 1'b0;
                    end
                end

                S_RUN: begin
                    // start is deliberately ignored while running.
                    if (bus.halt_instr) begin
                        // Halt beats a simultaneous taken branch; pc holds.
                        state         <= S_HALT;
                        fetch_valid_q <= 1'b0;
                        done_q        <= 1'b1;
                    end else if (branch_taken) begin
                        pc_q <= lut[bus.target_idx];
                    end else begin
                        pc_q <= pc_q + 1'b1;
                        if (pc_q == PC_MAX) begin
                            wrap_q <= 1'b1;
                        end
                    end
                end

                S_HALT: begin
                    fetch_valid_q <= 1'b0;
                    done_q        <= 1'b1;
                    if (bus.start) begin
                        state         <= S_RUN;
                        pc_q          <= '0;
                        fetch_valid_q <= 1'b1;
                        done_q        <= 1'b0;
                        wrap_q        <= 1'b0;
                    end
                end

                default: begin
                    state         <= S_IDLE;
                    pc_q          <= '0;
                    fetch_valid_q <= 1'b0;
                    done_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.done        = done_q;
    assign bus.wrap_flag   = wrap_q;

`ifdef PC_SEQ_CYCLE_COUNT_EN
    logic [15:0] cycle_cnt_q;

    // Counts every edge taken in RUN, including the one that samples halt.
    // A start that leaves IDLE/HALT restarts the count from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
        end else if (state != S_RUN && bus.start) begin
            cycle_cnt_q <= '0;
        end else if (state == S_RUN && cycle_cnt_q != 16'hFFFF) begin
            cycle_cnt_q <= cycle_cnt_q + 16'd1;
        end
    end

    assign bus.cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer: a table of directed vectors with
//   hand-derived expected outputs, an optional cycle-counter sequence, and a
//   randomized phase checked against a behavioural model of the sequencer.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int PW     = 10;
    localparam int LW     = 4;
    localparam int PC_MOD = 2 ** PW;
    localparam int LUT_N  = 2 ** LW;

    logic clk;
    logic reset;

    pc_sequencer_if #(.PW(PW), .LW(LW)) bus ();

    pc_sequencer #(.PW(PW), .LW(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst, st, hlt, ben, bc;
        logic [3:0] tidx;
        logic       we;
        logic [3:0] la;
        logic [9:0] ld;
        logic [9:0] e_pc;
        logic       e_fv, e_dn, e_wr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int rst, int st, int hlt, int ben, int bc, int tidx,
                                int we, int la, int ld,
                                int e_pc, int e_fv, int e_dn, int e_wr);
        vec_t v;
        v.rst = rst[0]; v.st = st[0]; v.hlt = hlt[0]; v.ben = ben[0]; v.bc = bc[0];
        v.tidx = tidx[3:0]; v.we = we[0]; v.la = la[3:0]; v.ld = ld[9:0];
        v.e_pc = e_pc[9:0]; v.e_fv = e_fv[0]; v.e_dn = e_dn[0]; v.e_wr = e_wr[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, st, hlt, ben, bc, input logic [3:0] tidx,
                         input logic we, input logic [3:0] la, input logic [9:0] ld);
        reset           = rst;
        bus.start       = st;
        bus.halt_instr  = hlt;
        bus.branch_en   = ben;
        bus.branch_cond = bc;
        bus.target_idx  = tidx;
        bus.lut_we      = we;
        bus.lut_addr    = la;
        bus.lut_data    = ld;
    endtask

    // Apply inputs, take one edge, then sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model state
    int  m_pc;
    bit  m_running, m_halted, m_wrap;
    int  m_lut[LUT_N];
    int  m_cnt;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Directed table: inputs for one edge, expected outputs after it.
        //            rst st hl be bc ti we la  ld      pc    fv dn wr
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,      0,    0, 0, 0)); // 0 reset
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,      0,    0, 0, 0)); // 1 reset
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,      0,    1, 0, 0)); // 2 start
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 'h040,  1,    1, 0, 0)); // 3 LUT[3]
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4, 'h005,  2,    1, 0, 0)); // 4 LUT[4]
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 'h012,  3,    1, 0, 0)); // 5 LUT[5]
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 'h020,  4,    1, 0, 0)); // 6 LUT[2]
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 'h3FE,  5,    1, 0, 0)); // 7 LUT[6]
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 0, 0, 0,      'h040,1, 0, 0)); // 8 taken
        vecs.push_back(mk(0, 0, 0, 1, 1, 4, 0, 0, 0,      5,    1, 0, 0)); // 9 back to 5
        vecs.push_back(mk(0, 0, 0, 1, 0, 3, 0, 0, 0,      6,    1, 0, 0)); // 10 not taken
        vecs.push_back(mk(0, 0, 0, 1, 1, 5, 0, 0, 0,      'h012,1, 0, 0)); // 11 to 0x12
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,      'h012,0, 1, 0)); // 12 halt
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      'h012,0, 1, 0)); // 13 hold
        vecs.push_back(mk(0, 0, 1, 1, 1, 3, 0, 0, 0,      'h012,0, 1, 0)); // 14 ignored
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,      0,    1, 0, 0)); // 15 restart
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1,    1, 0, 0)); // 16
        vecs.push_back(mk(0, 0, 1, 1, 1, 3, 0, 0, 0,      1,    0, 1, 0)); // 17 halt wins
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,      0,    1, 0, 0)); // 18 restart
        vecs.push_back(mk(0, 0, 0, 1, 1, 2, 1, 2, 'h100,  'h020,1, 0, 0)); // 19 old entry
        vecs.push_back(mk(0, 0, 0, 1, 1, 2, 0, 0, 0,      'h100,1, 0, 0)); // 20 new entry
        vecs.push_back(mk(0, 0, 0, 1, 1, 6, 0, 0, 0,      'h3FE,1, 0, 0)); // 21 near top
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      'h3FF,1, 0, 0)); // 22
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      0,    1, 0, 1)); // 23 wrap
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1,    1, 0, 1)); // 24 sticky
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,      2,    1, 0, 1)); // 25 start ignored
        vecs.push_back(mk(1, 0, 0, 1, 1, 3, 0, 0, 0,      0,    0, 0, 0)); // 26 reset mid-run
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,      0,    1, 0, 0)); // 27 start
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 0, 0, 0,      0,    1, 0, 0)); // 28 LUT cleared
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1,    1, 0, 0)); // 29

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].hlt, vecs[i].ben, vecs[i].bc,
                  vecs[i].tidx, vecs[i].we, vecs[i].la, vecs[i].ld);
            tick();
            chk($sformatf("vec%0d pc", i),          32'(bus.pc),          32'(vecs[i].e_pc));
            chk($sformatf("vec%0d fetch_valid", i), 32'(bus.fetch_valid), 32'(vecs[i].e_fv));
            chk($sformatf("vec%0d done", i),        32'(bus.done),        32'(vecs[i].e_dn));
            chk($sformatf("vec%0d wrap_flag", i),   32'(bus.wrap_flag),   32'(vecs[i].e_wr));
        end

`ifdef PC_SEQ_CYCLE_COUNT_EN
        // Cycle counter: start, 10 running edges, halt edge -> 11, holds, start clears.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("cnt after reset", 32'(bus.cycle_cnt), 32'd0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("cnt after start", 32'(bus.cycle_cnt), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) tick();
        chk("cnt running", 32'(bus.cycle_cnt), 32'd10);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0); tick();
        chk("cnt at halt", 32'(bus.cycle_cnt), 32'd11);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); tick(); tick();
        chk("cnt holds", 32'(bus.cycle_cnt), 32'd11);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("cnt cleared by start", 32'(bus.cycle_cnt), 32'd0);
        chk("pc after restart", 32'(bus.pc), 32'd0);
`endif

        // Randomized phase against the behavioural model. First cycle is a reset.
        for (int n = 0; n < 3000; n++) begin
            logic       r_rst, r_st, r_hlt, r_ben, r_bc, r_we;
            logic [3:0] r_tidx, r_la;
            logic [9:0] r_ld;
            int         old_target;

            r_rst  = (n == 0) || ($urandom_range(0, 63) == 0);
            r_st   = ($urandom_range(0, 7) == 0);
            r_hlt  = ($urandom_range(0, 15) == 0);
            r_ben  = ($urandom_range(0, 3) == 0);
            r_bc   = $urandom_range(0, 1);
            r_tidx = 4'($urandom_range(0, LUT_N - 1));
            r_we   = ($urandom_range(0, 3) == 0);
            r_la   = 4'($urandom_range(0, LUT_N - 1));
            // Bias some targets near the top of memory so wraps happen.
            r_ld   = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(PC_MOD - 16, PC_MOD - 1))
                                                 : 10'($urandom_range(0, PC_MOD - 1));
            drive(r_rst, r_st, r_hlt, r_ben, r_bc, r_tidx, r_we, r_la, r_ld);
            tick();

            if (r_rst) begin
                m_running = 0; m_halted = 0; m_pc = 0; m_wrap = 0; m_cnt = 0;
                for (int j = 0; j < LUT_N; j++) m_lut[j] = 0;
            end else begin
                old_target = m_lut[r_tidx];
                if (m_running) begin
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                    if (r_hlt) begin
                        m_running = 0;
                        m_halted  = 1;
                    end else if (r_ben && r_bc) begin
                        m_pc = old_target;
                    end else begin
                        if (m_pc == PC_MOD - 1) m_wrap = 1;
                        m_pc = (m_pc + 1) % PC_MOD;
                    end
                end else if (r_st) begin
                    m_running = 1; m_halted = 0; m_pc = 0; m_wrap = 0; m_cnt = 0;
                end
                if (r_we) m_lut[r_la] = r_ld;
            end

            chk($sformatf("rnd%0d pc", n),          32'(bus.pc),          32'(m_pc));
            chk($sformatf("rnd%0d fetch_valid", n), 32'(bus.fetch_valid), 32'(m_running));
            chk($sformatf("rnd%0d done", n),        32'(bus.done),        32'(m_halted));
            chk($sformatf("rnd%0d wrap_flag", n),   32'(bus.wrap_flag),   32'(m_wrap));
`ifdef PC_SEQ_CYCLE_COUNT_EN
            chk($sformatf("rnd%0d cycle_cnt", n),   32'(bus.cycle_cnt),   32'(m_cnt));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
